// File: rtl/arith_pkg.sv
// Shared types for seq_arith_unit: opcode and FSM state encodings.
package arith_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ADDSUB = 2'b01,
      ITER   = 2'b10,
      FINISH = 2'b11
   } state_t;

endpackage

// File: rtl/ripple_add_sub.sv
// N-bit ripple-carry adder/subtractor; sub=1 computes a - b as a + ~b + 1.
module ripple_add_sub #(
   parameter int N = 5
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N-1:0] bb;
   logic [N:0]   c;

   always_comb begin
      bb   = b ^ {N{sub}};
      c    = '0;
      sum  = '0;
      c[0] = sub;
      for (int i = 0; i < N; i++) begin
         sum[i]   = a[i] ^ bb[i] ^ c[i];
         c[i+1]   = (a[i] & bb[i]) | (c[i] & (a[i] ^ bb[i]));
      end
      cout = c[N];
   end

endmodule

// File: rtl/seq_arith_unit.sv
// Multi-cycle add/sub/shift-add multiply/restoring divide with start/busy/done.
// Define ARITH_SIGNED_EN for two's-complement operands; default build is unsigned.
module seq_arith_unit
   import arith_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [1:0]         sel,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] out,
   output logic               carry,
   output logic               div_zero
);

   localparam int W2 = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   // Handshake: start is sampled only in IDLE; busy is high from the capture
   // edge until the result edge; done pulses for the single cycle after out,
   // carry and div_zero update. A start seen while busy is dropped.

   state_t            state;
   op_t               op;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic [W2-1:0]     acc;
   logic [CW-1:0]     cnt;
   logic              dz;

   logic [WIDTH:0]    ra;
   logic [WIDTH:0]    rb;
   logic [WIDTH:0]    rs;
   logic              rsub;
   logic              rco;

   logic [WIDTH-1:0]  xm;
   logic [WIDTH-1:0]  ym;
   logic [W2-1:0]     fin;

   ripple_add_sub #(.N(WIDTH + 1)) u_alu (
      .a    (ra),
      .b    (rb),
      .sub  (rsub),
      .sum  (rs),
      .cout (rco)
   );

   // One datapath serves add/sub, the multiply accumulate and the divide trial.
   always_comb begin
      ra   = '0;
      rb   = '0;
      rsub = 1'b0;
      case (state)
         ADDSUB: begin
`ifdef ARITH_SIGNED_EN
            ra = {a[WIDTH-1], a};
            rb = {b[WIDTH-1], b};
`else
            ra = {1'b0, a};
            rb = {1'b0, b};
`endif
            rsub = (op == OP_SUB);
         end
         ITER: begin
            if (op == OP_MUL) begin
               ra = {1'b0, acc[W2-1:WIDTH]};
               rb = acc[0] ? {1'b0, b} : '0;
            end else begin
               ra   = acc[W2-1:WIDTH-1];
               rb   = {1'b0, b};
               rsub = 1'b1;
            end
         end
         default: ;
      endcase
   end

`ifdef ARITH_SIGNED_EN
   logic neg_q;
   logic neg_r;

   always_comb begin
      xm = x[WIDTH-1] ? (~x + 1'b1) : x;
      ym = y[WIDTH-1] ? (~y + 1'b1) : y;
   end

   // Sign fix-up of the unsigned core result, applied on the FINISH edge.
   always_comb begin
      fin = acc;
      if (op == OP_MUL) begin
         if (neg_q) fin = ~acc + 1'b1;
      end else if (!dz) begin
         fin[W2-1:WIDTH]  = neg_r ? (~acc[W2-1:WIDTH] + 1'b1) : acc[W2-1:WIDTH];
         fin[WIDTH-1:0]   = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
      end
   end
`else
   always_comb begin
      xm  = x;
      ym  = y;
      fin = acc;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         op       <= OP_ADD;
         a        <= '0;
         b        <= '0;
         acc      <= '0;
         cnt      <= '0;
         dz       <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         out      <= '0;
         carry    <= 1'b0;
         div_zero <= 1'b0;
`ifdef ARITH_SIGNED_EN
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op   <= op_t'(sel);
                  a    <= x;
                  b    <= y;
                  cnt  <= '0;
                  dz   <= (sel == OP_DIV) && (y == '0);
                  busy <= 1'b1;
`ifdef ARITH_SIGNED_EN
                  neg_q <= x[WIDTH-1] ^ y[WIDTH-1];
                  neg_r <= x[WIDTH-1];
`endif
                  if (sel[1]) begin
                     state <= ITER;
                     // Multiplier bits live in the low half of acc, multiplicand in b.
                     if (sel == OP_MUL) begin
                        acc <= {{WIDTH{1'b0}}, ym};
                        b   <= xm;
                     end else begin
                        acc <= {{WIDTH{1'b0}}, xm};
                        b   <= ym;
                     end
                  end else begin
                     state <= ADDSUB;
                  end
               end
            end
            ADDSUB: begin
`ifdef ARITH_SIGNED_EN
               out   <= {{(WIDTH-1){rs[WIDTH]}}, rs};
               carry <= rs[WIDTH] ^ rs[WIDTH-1];
`else
               out   <= (op == OP_ADD) ? {{(WIDTH-1){1'b0}}, rs}
                                       : {{(WIDTH-1){rs[WIDTH]}}, rs};
               carry <= rs[WIDTH];
`endif
               div_zero <= 1'b0;
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            ITER: begin
               if (dz) begin
                  acc   <= {a, {WIDTH{1'b1}}};
                  state <= FINISH;
               end else begin
                  if (op == OP_MUL) begin
                     acc <= {rs, acc[WIDTH-1:1]};
                  end else begin
                     // Keep the trial difference only when it did not borrow.
                     acc <= {(rco ? rs[WIDTH-1:0] : ra[WIDTH-1:0]),
                             acc[WIDTH-2:0], rco};
                  end
                  cnt <= cnt + CW'(1);
                  if (cnt == CW'(WIDTH - 1)) state <= FINISH;
               end
            end
            FINISH: begin
               out      <= fin;
               carry    <= 1'b0;
               div_zero <= dz;
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Self-checking bench for seq_arith_unit (WIDTH=4); honours ARITH_SIGNED_EN.
module tb_seq_arith_unit;

   localparam int W = 4;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [1:0]     sel;
   logic [W-1:0]   x;
   logic [W-1:0]   y;
   logic           busy;
   logic           done;
   logic [2*W-1:0] out;
   logic           carry;
   logic           div_zero;

   int total = 0;
   int bad   = 0;

   // {div_zero, carry, out}
   logic [2*W+1:0] exp_q[$];
   int             lat_q[$];

   seq_arith_unit #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .sel      (sel),
      .x        (x),
      .y        (y),
      .busy     (busy),
      .done     (done),
      .out      (out),
      .carry    (carry),
      .div_zero (div_zero)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int sx(input logic [W-1:0] v);
`ifdef ARITH_SIGNED_EN
      return v[W-1] ? int'(v) - (1 << W) : int'(v);
`else
      return int'(v);
`endif
   endfunction

   // Reference model: {div_zero, carry, out}
   function automatic logic [2*W+1:0] model(input logic [1:0] s, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      int xa, yb, r;
      logic [2*W-1:0] o;
      logic c, dz;
      xa = sx(a);
      yb = sx(b);
      c  = 1'b0;
      dz = 1'b0;
      case (s)
         2'b00: begin
            r = xa + yb;
            o = r[2*W-1:0];
`ifdef ARITH_SIGNED_EN
            c = (r > 7) || (r < -8);
`else
            c = r[W];
`endif
         end
         2'b01: begin
            r = xa - yb;
            o = r[2*W-1:0];
`ifdef ARITH_SIGNED_EN
            c = (r > 7) || (r < -8);
`else
            c = (a < b);
`endif
         end
         2'b10: begin
            r = xa * yb;
            o = r[2*W-1:0];
         end
         default: begin
            if (b == '0) begin
               o  = {a, {W{1'b1}}};
               dz = 1'b1;
            end else begin
               int q, m;
               q = xa / yb;
               m = xa % yb;
               o = {m[W-1:0], q[W-1:0]};
            end
         end
      endcase
      return {dz, c, o};
   endfunction

   // Driver: launches one op, pushes expectations, waits for done and scores it.
   // poke=1 pulses start (as an add) while the op is busy.
   task automatic run_op(input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit poke);
      int cycles;
      int ndone;
      logic [2*W+1:0] e;
      @(negedge clk);
      sel   = s;
      x     = a;
      y     = b;
      start = 1'b1;
      exp_q.push_back(model(s, a, b));
      lat_q.push_back(s[1] ? ((s == 2'b11 && b == '0) ? 2 : W + 1) : 1);
      @(posedge clk);
      #1;
      start = 1'b0;
      x     = ~a;
      y     = ~b;
      chk("busy_after_start", busy, 1'b1);
      cycles = 0;
      while (1) begin
         @(posedge clk);
         #1;
         cycles++;
         if (poke && cycles == 2) begin
            start = 1'b1;
            sel   = 2'b00;
            x     = 1;
            y     = 1;
         end
         if (poke && cycles == 3) start = 1'b0;
         if (done) break;
         if (cycles >= 20) begin
            chk("done_timeout", 0, 1);
            break;
         end
      end
      start = 1'b0;
      e = exp_q.pop_front();
      chk("latency", cycles, lat_q.pop_front());
      chk("busy_at_done", busy, 1'b0);
      chk("out", out, e[2*W-1:0]);
      chk("carry", carry, e[2*W]);
      chk("div_zero", div_zero, e[2*W+1]);
      @(posedge clk);
      #1;
      chk("done_pulse_len", done, 1'b0);
      chk("out_hold", out, e[2*W-1:0]);
      if (poke) begin
         ndone = 0;
         repeat (8) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
         end
         chk("poke_ignored", ndone, 0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      sel   = 2'b00;
      x     = '0;
      y     = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_out", out, 0);
      chk("rst_carry", carry, 1'b0);
      chk("rst_dz", div_zero, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(2'b00, 4'd9,  4'd8, 0);
      run_op(2'b01, 4'd3,  4'd5, 0);
      run_op(2'b01, 4'd5,  4'd3, 0);
      run_op(2'b10, 4'd15, 4'd15, 1);
      run_op(2'b11, 4'd13, 4'd4, 0);
      run_op(2'b11, 4'd7,  4'd0, 0);
      run_op(2'b11, 4'd15, 4'd1, 0);
      run_op(2'b10, 4'd0,  4'd9, 0);
      run_op(2'b00, 4'd15, 4'd15, 0);
`ifdef ARITH_SIGNED_EN
      run_op(2'b10, 4'hD, 4'd5, 0);
      run_op(2'b11, 4'h9, 4'd2, 0);
      run_op(2'b11, 4'h8, 4'hF, 0);
`endif

      for (int i = 0; i < 24; i++) begin
         run_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 0);
      end

      // Asynchronous reset in the middle of a multiply.
      @(negedge clk);
      sel   = 2'b10;
      x     = 4'd7;
      y     = 4'd6;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      chk("midrst_out", out, 0);
      chk("midrst_carry", carry, 1'b0);
      chk("midrst_dz", div_zero, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(2'b00, 4'd2, 4'd2, 0);

      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
